// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents:
//   DEFAULT_DATA_W  default data/address width
//   state_e         arbiter FSM states
//   GNT_I / GNT_D   grant-select encodings (fetch / data)
package mips_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the arbiter.
// Modports:
//   master  arbiter view: takes requests and mem response, drives acks,
//           read data, stall, the memory request and err
//   slave   environment view: the pipeline requesters and the memory
interface mem_port_arbiter_if #(
  parameter int DATA_W = mips_mem_pkg::DEFAULT_DATA_W
);

  // Instruction fetch port
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data port (EX/MEM)
  logic              dm_read;
  logic              dm_write;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // Pipeline control
  logic              stall;
  logic              err;

  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
           mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
           mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, stall, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_watchdog.sv
// Busy-cycle watchdog for the memory port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr_i       restart the count (access being granted)
//   en_i        one more busy cycle without mem_ready
//   expired_o   single-cycle pulse: this cycle is busy cycle number TIMEOUT
//               without a response
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (en_i)  count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // The count holds the stalled cycles already seen, so the cycle that would
  // bring it to TIMEOUT is the one that expires.
  assign expired_o = en_i & ~clr_i & (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between
// instruction fetch and the EX/MEM data access.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus_if     mem_port_arbiter_if.master: fetch port (if_*), data port
//              (dm_*), pipeline stall, sticky err and the memory port (mem_*)
// Data beats fetch unless fetch has waited through STARVE_MAX data grants.
// A busy state that sees no mem_ready for TIMEOUT cycles traps in ERR until
// reset.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus_if
);

  localparam int               STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic dm_pend, if_pend, gnt;
  logic wd_clr, wd_en, wd_expired;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // A requester whose ack is high is in its release cycle; whatever it
  // presents now belongs to the next access and must not win this cycle.
  assign dm_pend = (bus_if.dm_read | bus_if.dm_write) & ~dm_ack_q;
  assign if_pend = bus_if.if_req & ~if_ack_q;

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = err_q;
    starve_d    = starve_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    gnt         = (dm_pend && !(if_pend && starve_q == STV_MAX)) ? GNT_D : GNT_I;

    unique case (state_q)
      IDLE: begin
        if (dm_pend || if_pend) begin
          wd_clr = 1'b1;
          if (gnt == GNT_D) begin
            state_d     = BUSY_D;
            mem_addr_d  = bus_if.dm_addr;
            // Read and write together is treated as a store.
            mem_we_d    = bus_if.dm_write;
            mem_wdata_d = bus_if.dm_write ? bus_if.dm_wdata : '0;
            if (!if_pend)                starve_d = '0;
            else if (starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);
          end else begin
            state_d     = BUSY_I;
            mem_addr_d  = bus_if.if_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end

      BUSY_D, BUSY_I: begin
        wd_en = ~bus_if.mem_ready;
        if (bus_if.mem_ready) begin
          state_d = IDLE;
          if (state_q == BUSY_D) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus_if.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_if.mem_rdata;
          end
        end else if (wd_expired) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end

      ERR: state_d = ERR;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset clears every register, including captured
    // read data and the held memory address, so outputs are defined at once.
    if (rst) begin
      state_q     <= IDLE;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
    end
  end

  assign bus_if.if_rdata  = if_rdata_q;
  assign bus_if.if_ack    = if_ack_q;
  assign bus_if.dm_rdata  = dm_rdata_q;
  assign bus_if.dm_ack    = dm_ack_q;
  assign bus_if.err       = err_q;
  assign bus_if.mem_addr  = mem_addr_q;
  assign bus_if.mem_wdata = mem_wdata_q;
  assign bus_if.mem_we    = mem_we_q;
  // mem_req is a decode of the state register, so it drops on the same edge
  // that completes, traps or resets the access.
  assign bus_if.mem_req   = (state_q == BUSY_D) || (state_q == BUSY_I);

  // Low in the ack cycle, so the pipeline advances once per access.
  assign bus_if.stall = err_q
                      | ((bus_if.dm_read | bus_if.dm_write) & ~dm_ack_q)
                      | (bus_if.if_req & ~if_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory, with every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .DATA_W     (DW),
    .STARVE_MAX (SMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: who owns the memory, how long it has waited, how many
  // data accesses fetch has been passed over for.
  // ---------------------------------------------------------------------
  typedef enum int {M_NONE, M_DATA, M_FETCH, M_HUNG} owner_t;

  owner_t      m_owner;
  int          m_busy;     // busy cycles already spent without a response
  int          m_starve;   // data grants taken while fetch was waiting
  bit          m_err, m_if_ack, m_dm_ack, m_we;
  logic [31:0] m_if_rdata, m_dm_rdata, m_addr, m_wdata;

  logic m_dpend, m_ipend;
  assign m_dpend = (bus.dm_read | bus.dm_write) & ~m_dm_ack;
  assign m_ipend = bus.if_req & ~m_if_ack;

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= M_NONE; m_busy <= 0; m_starve <= 0; m_err <= 1'b0;
      m_if_ack <= 1'b0; m_dm_ack <= 1'b0; m_we <= 1'b0;
      m_if_rdata <= '0; m_dm_rdata <= '0; m_addr <= '0; m_wdata <= '0;
    end else begin
      m_if_ack <= 1'b0;
      m_dm_ack <= 1'b0;
      case (m_owner)
        M_NONE: begin
          if (m_dpend && !(m_ipend && m_starve == SMAX)) begin
            m_owner  <= M_DATA;
            m_busy   <= 0;
            m_addr   <= bus.dm_addr;
            m_we     <= bus.dm_write;
            m_wdata  <= bus.dm_write ? bus.dm_wdata : 32'h0;
            m_starve <= m_ipend ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
          end else if (m_ipend) begin
            m_owner  <= M_FETCH;
            m_busy   <= 0;
            m_addr   <= bus.if_addr;
            m_we     <= 1'b0;
            m_wdata  <= 32'h0;
            m_starve <= 0;
          end
        end
        M_DATA, M_FETCH: begin
          if (bus.mem_ready) begin
            m_owner <= M_NONE;
            if (m_owner == M_DATA) begin
              m_dm_ack <= 1'b1;
              if (!m_we) m_dm_rdata <= bus.mem_rdata;
            end else begin
              m_if_ack   <= 1'b1;
              m_if_rdata <= bus.mem_rdata;
            end
          end else begin
            m_busy <= m_busy + 1;
            if (m_busy + 1 == TMO) begin
              m_owner <= M_HUNG;
              m_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("cmp_if_ack",    bus.if_ack,    m_if_ack);
      check("cmp_dm_ack",    bus.dm_ack,    m_dm_ack);
      check("cmp_if_rdata",  bus.if_rdata,  m_if_rdata);
      check("cmp_dm_rdata",  bus.dm_rdata,  m_dm_rdata);
      check("cmp_mem_req",   bus.mem_req,   (m_owner == M_DATA || m_owner == M_FETCH));
      check("cmp_mem_addr",  bus.mem_addr,  m_addr);
      check("cmp_mem_we",    bus.mem_we,    m_we);
      check("cmp_mem_wdata", bus.mem_wdata, m_wdata);
      check("cmp_err",       bus.err,       m_err);
      check("cmp_stall",     bus.stall,     m_err | m_dpend | m_ipend);
    end
  end

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_read = 0; bus.dm_write = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    rst = 1;
    wait_clk();
    started = 1'b1;
    wait_clk();
    check("rst_mem_req",  bus.mem_req,  0);
    check("rst_mem_we",   bus.mem_we,   0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_err",      bus.err,      0);
    check("rst_stall",    bus.stall,    0);
    rst = 0;

    // Load, zero wait states; mem_ready stays high afterwards and must be
    // ignored while nothing is requested.
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    bus.dm_read = 1; bus.dm_addr = 32'h40;
    #1 check("ld_stall_c0", bus.stall, 1);
    wait_clk();
    check("ld_req_c1",   bus.mem_req,  1);
    check("ld_addr_c1",  bus.mem_addr, 32'h40);
    check("ld_we_c1",    bus.mem_we,   0);
    check("ld_stall_c1", bus.stall,    1);
    wait_clk();
    check("ld_ack_c2",   bus.dm_ack,   1);
    check("ld_rdata_c2", bus.dm_rdata, 32'hDEADBEEF);
    check("ld_stall_c2", bus.stall,    0);
    check("ld_req_c2",   bus.mem_req,  0);
    bus.dm_read = 0;
    wait_clk();
    check("ld_ack_c3",   bus.dm_ack,   0);
    check("ld_req_c3",   bus.mem_req,  0);

    // Store with three wait states.
    bus.mem_ready = 0; bus.mem_rdata = 32'h55555555;
    bus.dm_write = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      wait_clk();
      check("st_req",   bus.mem_req,   1);
      check("st_we",    bus.mem_we,    1);
      check("st_addr",  bus.mem_addr,  32'h80);
      check("st_wdata", bus.mem_wdata, 32'h12345678);
      check("st_noack", bus.dm_ack,    0);
      if (k == 4) bus.mem_ready = 1;
    end
    wait_clk();
    check("st_ack_c5",   bus.dm_ack,   1);
    check("st_rdata_c5", bus.dm_rdata, 32'hDEADBEEF);
    check("st_stall_c5", bus.stall,    0);
    bus.dm_write = 0; bus.mem_ready = 0;
    wait_clk();

    // Contention: data first, then fetch.
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE0001;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.dm_read = 1; bus.dm_addr = 32'h44;
    wait_clk();
    check("ct_addr_c1",  bus.mem_addr, 32'h44);
    check("ct_we_c1",    bus.mem_we,   0);
    wait_clk();
    check("ct_dmack_c2", bus.dm_ack,   1);
    check("ct_ifack_c2", bus.if_ack,   0);
    check("ct_dmrd_c2",  bus.dm_rdata, 32'hCAFE0001);
    check("ct_stall_c2", bus.stall,    1);
    bus.dm_read = 0; bus.mem_rdata = 32'hCAFE0002;
    wait_clk();
    check("ct_req_c3",   bus.mem_req,  1);
    check("ct_addr_c3",  bus.mem_addr, 32'h100);
    wait_clk();
    check("ct_ifack_c4", bus.if_ack,   1);
    check("ct_ifrd_c4",  bus.if_rdata, 32'hCAFE0002);
    check("ct_stall_c4", bus.stall,    0);
    bus.if_req = 0;
    wait_clk();

    // Starvation: fetch waits through exactly SMAX data grants.
    bus.mem_ready = 1; bus.mem_rdata = 32'h11110000;
    bus.dm_read = 1; bus.dm_addr = 32'h200;
    bus.if_req = 1; bus.if_addr = 32'h300;
    for (int g = 0; g <= SMAX; g++) begin
      wait_clk();
      check("sv_req",  bus.mem_req,  1);
      check("sv_gnt",  bus.mem_addr, (g < SMAX) ? 32'h200 : 32'h300);
      wait_clk();
      if (g < SMAX) begin
        check("sv_dmack", bus.dm_ack, 1);
        bus.if_req = 0;
        wait_clk();
        check("sv_idle", bus.mem_req, 0);
        bus.if_req = 1;
      end else begin
        check("sv_ifack", bus.if_ack, 1);
        bus.if_req = 0; bus.dm_read = 0;
      end
    end
    wait_clk();
    bus.dm_read = 1; bus.if_req = 1;
    wait_clk();
    check("sv_reset_gnt", bus.mem_addr, 32'h200);
    wait_clk();
    bus.dm_read = 0; bus.if_req = 0;
    wait_clk();
    wait_clk();

    // Watchdog timeout.
    bus.mem_ready = 0;
    bus.dm_read = 1; bus.dm_addr = 32'h500;
    for (int k = 1; k <= TMO; k++) begin
      wait_clk();
      check("to_busy_req", bus.mem_req, 1);
      check("to_busy_err", bus.err,     0);
    end
    wait_clk();
    check("to_err",   bus.err,     1);
    check("to_req",   bus.mem_req, 0);
    check("to_stall", bus.stall,   1);
    bus.dm_read = 0; bus.mem_ready = 1; bus.if_req = 1; bus.if_addr = 32'h700;
    repeat (3) wait_clk();
    check("to_hold_ack",   bus.if_ack,  0);
    check("to_hold_req",   bus.mem_req, 0);
    check("to_hold_stall", bus.stall,   1);
    check("to_hold_err",   bus.err,     1);
    rst = 1; bus.if_req = 0; bus.mem_ready = 0;
    wait_clk();
    check("to_rst_err",   bus.err,     0);
    check("to_rst_req",   bus.mem_req, 0);
    check("to_rst_stall", bus.stall,   0);
    rst = 0;
    wait_clk();

    // Reset in the middle of a fetch.
    bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
    bus.if_req = 1; bus.if_addr = 32'h600;
    wait_clk();
    wait_clk();
    check("rm_ifack",  bus.if_ack,   1);
    check("rm_ifrd",   bus.if_rdata, 32'h0BADF00D);
    bus.if_req = 0; bus.mem_ready = 0;
    wait_clk();
    bus.if_req = 1; bus.if_addr = 32'h604;
    wait_clk();
    check("rm_req_c1",  bus.mem_req,  1);
    check("rm_addr_c1", bus.mem_addr, 32'h604);
    wait_clk();
    rst = 1; bus.mem_ready = 1;
    wait_clk();
    check("rm_req",   bus.mem_req,  0);
    check("rm_ack",   bus.if_ack,   0);
    check("rm_ifrd0", bus.if_rdata, 0);
    rst = 0; bus.if_req = 0; bus.mem_ready = 0;
    wait_clk();

    // Randomized traffic; requesters hold until acked, memory answers at
    // random (also while idle), with the odd reset thrown in.
    for (int c = 0; c < 3000; c++) begin
      wait_clk();
      if (!bus.if_req || bus.if_ack) begin
        bus.if_req  = ($urandom_range(0, 9) < 4);
        bus.if_addr = $urandom;
      end
      if (!(bus.dm_read || bus.dm_write) || bus.dm_ack) begin
        int r;
        r = $urandom_range(0, 9);
        bus.dm_read  = (r < 2) || (r == 4);
        bus.dm_write = (r == 2) || (r == 3) || (r == 4);
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
      end
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.mem_rdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    wait_clk();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
